// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the beat-driven song sequencer.
// ROM words are {note, duration}: note in the MSBs, duration in the LSBs.
package note_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StWait  = 3'd2,
        StPlay  = 3'd3,
        StDone  = 3'd4
    } seq_state_e;

    // A duration of zero marks the end of the song.
    localparam int unsigned EndMarker = 0;

endpackage

// File: rtl/note_sequencer_beat_down_counter.sv
// Remaining-beats counter for the current note: clear, load, decrement-on-enable,
// and an is_one flag that tells the sequencer the next beat expires the note.
module note_sequencer_beat_down_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q > WIDTH'(1))) begin
            // Floor at one: expiry is handled by the sequencer, never by wrapping here.
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/note_sequencer.sv
// Beat-driven song sequencer: fetches {note, duration} words from a synchronous ROM
// and presents each note for its duration in beat pulses.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned NOTE_WIDTH = 6,
    parameter int unsigned DUR_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic                          restart,
    input  logic                          beat,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [NOTE_WIDTH+DUR_WIDTH-1:0] rom_data,
    output logic [NOTE_WIDTH-1:0]         note,
    output logic                          note_valid,
    output logic                          new_note,
    output logic                          song_done
);

    localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

    seq_state_e            state_d, state_q;
    logic [ADDR_WIDTH-1:0] rom_addr_d, rom_addr_q;
    logic [NOTE_WIDTH-1:0] note_d, note_q;
    logic                  has_note_d, has_note_q;
    logic                  new_note_d, new_note_q;

    logic                  cnt_clear, cnt_load, cnt_dec, cnt_is_one;
    logic [NOTE_WIDTH-1:0] rom_note;
    logic [DUR_WIDTH-1:0]  rom_dur;

    assign rom_note = rom_data[NOTE_WIDTH+DUR_WIDTH-1 -: NOTE_WIDTH];
    assign rom_dur  = rom_data[DUR_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        has_note_d = has_note_q;
        new_note_d = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        if (restart) begin
            // Restart wins over everything, including an expiring beat.
            state_d    = StIdle;
            rom_addr_d = '0;
            note_d     = '0;
            has_note_d = 1'b0;
            cnt_clear  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (play) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    state_d = StWait;
                end
                StWait: begin
                    if (rom_dur == DUR_WIDTH'(EndMarker)) begin
                        state_d = StDone;
                    end else begin
                        note_d     = rom_note;
                        has_note_d = 1'b1;
                        new_note_d = 1'b1;
                        cnt_load   = 1'b1;
                        state_d    = StPlay;
                    end
                end
                StPlay: begin
                    if (beat && play) begin
                        if (!cnt_is_one) begin
                            cnt_dec = 1'b1;
                        end else if (rom_addr_q == AddrMax) begin
                            state_d = StDone;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                            state_d    = StFetch;
                        end
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            note_q     <= '0;
            has_note_q <= 1'b0;
            new_note_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            note_q     <= note_d;
            has_note_q <= has_note_d;
            new_note_q <= new_note_d;
        end
    end

    note_sequencer_beat_down_counter #(
        .WIDTH (DUR_WIDTH)
    ) u_remaining (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (rom_dur),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_is_one)
    );

    assign rom_addr   = rom_addr_q;
    assign note       = note_q;
    assign new_note   = new_note_q;
    // The previous note keeps sounding through FETCH/WAIT so there is no gap.
    assign note_valid = has_note_q && play && (state_q != StDone) && (state_q != StIdle);
    assign song_done  = (state_q == StDone);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with a behavioural synchronous song ROM.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        restart;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note;
    logic        note_valid;
    logic        new_note;
    logic        song_done;

    logic [11:0] rom [128];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    note_sequencer #(
        .ADDR_WIDTH (7),
        .NOTE_WIDTH (6),
        .DUR_WIDTH  (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .restart    (restart),
        .beat       (beat),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .note_valid (note_valid),
        .new_note   (new_note),
        .song_done  (song_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 12'h000;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        play    = 1'b0;
        restart = 1'b0;
        beat    = 1'b0;
        rom_data = '0;
        clear_rom();
        rom[0] = {6'd5, 6'd2};
        rom[1] = {6'd9, 6'd1};
        rom[2] = {6'd0, 6'd0};

        #12;
        check_eq("rst_addr", rom_addr, 0);
        check_eq("rst_note", note, 0);
        check_eq("rst_valid", note_valid, 0);
        check_eq("rst_new", new_note, 0);
        check_eq("rst_done", song_done, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic song: {5,2},{9,1},end
        play = 1'b1;
        tick();
        check_eq("start_fetch_new", new_note, 0);
        check_eq("start_fetch_valid", note_valid, 0);
        tick();
        tick();
        check_eq("first_new", new_note, 1);
        check_eq("first_note", note, 5);
        check_eq("first_valid", note_valid, 1);
        tick();
        check_eq("first_new_drop", new_note, 0);
        pulse_beat();
        check_eq("beat1_addr", rom_addr, 0);
        pulse_beat();
        check_eq("expire_addr", rom_addr, 1);
        check_eq("gap_note", note, 5);
        check_eq("gap_valid", note_valid, 1);
        tick();
        check_eq("gap2_new", new_note, 0);
        tick();
        check_eq("second_note", note, 9);
        check_eq("second_new", new_note, 1);
        pulse_beat();
        tick();
        tick();
        check_eq("end_done", song_done, 1);
        check_eq("end_valid", note_valid, 0);
        check_eq("end_note", note, 9);
        pulse_beat();
        tick();
        check_eq("done_hold_addr", rom_addr, 2);
        check_eq("done_hold", song_done, 1);

        // Pause mid-note with three beats remaining
        clear_rom();
        rom[0] = {6'd7, 6'd4};
        rom[1] = {6'd11, 6'd2};
        do_restart();
        check_eq("restart_addr", rom_addr, 0);
        check_eq("restart_done", song_done, 0);
        check_eq("restart_note", note, 0);
        tick();
        tick();
        tick();
        check_eq("p_new", new_note, 1);
        check_eq("p_note", note, 7);
        pulse_beat();
        play = 1'b0;
        #1;
        check_eq("pause_valid", note_valid, 0);
        for (int i = 0; i < 4; i++) pulse_beat();
        check_eq("pause_note", note, 7);
        check_eq("pause_addr", rom_addr, 0);
        play = 1'b1;
        #1;
        check_eq("resume_valid", note_valid, 1);
        pulse_beat();
        pulse_beat();
        check_eq("resume_2beats_addr", rom_addr, 0);
        pulse_beat();
        check_eq("resume_3beats_addr", rom_addr, 1);
        tick();
        tick();
        check_eq("resume_next_note", note, 11);
        check_eq("resume_next_new", new_note, 1);

        // Restart coincident with the expiring beat
        pulse_beat();
        beat    = 1'b1;
        restart = 1'b1;
        tick();
        beat    = 1'b0;
        restart = 1'b0;
        check_eq("rb_addr", rom_addr, 0);
        check_eq("rb_note", note, 0);
        check_eq("rb_valid", note_valid, 0);
        tick();
        tick();
        tick();
        check_eq("rb_new", new_note, 1);
        check_eq("rb_entry0", note, 7);
        check_eq("rb_addr_after", rom_addr, 0);

        // Beats during FETCH and WAIT are dropped
        pulse_beat();
        pulse_beat();
        pulse_beat();
        beat = 1'b1;
        tick();
        tick();
        tick();
        beat = 1'b0;
        check_eq("fw_new", new_note, 1);
        check_eq("fw_note", note, 11);
        pulse_beat();
        check_eq("fw_beat1_addr", rom_addr, 1);
        pulse_beat();
        check_eq("fw_beat2_addr", rom_addr, 2);
        tick();
        tick();
        check_eq("fw_done", song_done, 1);

        // Asynchronous reset while in WAIT
        clear_rom();
        rom[0] = {6'd3, 6'd1};
        rom[1] = {6'd4, 6'd1};
        do_restart();
        tick();
        tick();
        tick();
        check_eq("ar_first_note", note, 3);
        pulse_beat();
        tick();
        check_eq("ar_wait_addr", rom_addr, 1);
        check_eq("ar_wait_valid", note_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_addr", rom_addr, 0);
        check_eq("ar_note", note, 0);
        check_eq("ar_valid", note_valid, 0);
        check_eq("ar_new", new_note, 0);
        check_eq("ar_done", song_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("ar_rel_valid", note_valid, 0);
        tick();
        tick();
        tick();
        check_eq("ar_rel_new", new_note, 1);
        check_eq("ar_rel_note", note, 3);

        // Full ROM of one-beat notes, no end marker: stop at the last address
        for (int i = 0; i < 128; i++) rom[i] = {i[5:0], 6'd1};
        do_restart();
        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 8 && !new_note; k++) tick();
            check_eq("wrap_new", new_note, 1);
            check_eq("wrap_note", note, i & 63);
            pulse_beat();
        end
        check_eq("wrap_done", song_done, 1);
        check_eq("wrap_addr", rom_addr, 127);
        pulse_beat();
        tick();
        check_eq("wrap_hold_addr", rom_addr, 127);
        check_eq("wrap_hold_done", song_done, 1);
        check_eq("wrap_hold_valid", note_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
